seq_nonrestoring_divider: RTL and testbench

//  Iterative radix-2 non-restoring unsigned divider: q = a / b, r = a % b.

---
 rtl/seq_nonrestoring_divider.sv | 151 +++++++++++++++
 tb/tb_seq_nonrestoring_divider.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_nonrestoring_divider.sv
// rtl/seq_nonrestoring_divider.sv - iterative radix-2 non-restoring unsigned divider, one quotient bit per clock
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes in one edge and raises dz.
module seq_nonrestoring_divider #(
    parameter int WIDTH = 24,
    parameter int CNTW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             ready,
    output logic             dz
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             accept;
    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   p_step;
    logic [WIDTH-1:0] r_fix;

    assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

    // Partial remainder is signed WIDTH+1 bits; its MSB selects add or subtract.
    assign p_shift = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
    assign p_step  = p_q[WIDTH] ? p_shift + {1'b0, b_q} : p_shift - {1'b0, b_q};
    assign r_fix   = p_q[WIDTH] ? p_q[WIDTH-1:0] + b_q : p_q[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
`ifdef DIV_ZERO_FAST_EN
                    state_d = (b == '0) ? S_DONE : S_RUN;
`else
                    state_d = S_RUN;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN:   state_d = (cnt_q == CNTW'(1)) ? S_FIX : S_RUN;
            S_FIX:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == S_RUN) || (state_q == S_FIX);
        ready = (state_q == S_DONE);
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        p_d   = p_q;
        cnt_d = cnt_q;
        q_d   = q_q;
        r_d   = r_q;
        if (state_q == S_RUN) begin
            p_d   = p_step;
            a_d   = {a_q[WIDTH-2:0], ~p_step[WIDTH]};
            cnt_d = cnt_q - CNTW'(1);
        end else if (state_q == S_FIX) begin
            q_d = a_q;
            r_d = r_fix;
        end else if (accept) begin
            a_d   = a;
            b_d   = b;
            p_d   = '0;
            cnt_d = CNTW'(WIDTH);
`ifdef DIV_ZERO_FAST_EN
            if (b == '0) begin
                q_d = '1;
                r_d = a;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            cnt_q <= '0;
            q_q   <= '0;
            r_q   <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            p_q   <= p_d;
            cnt_q <= cnt_d;
            q_q   <= q_d;
            r_q   <= r_d;
        end
    end

    assign q = q_q;
    assign r = r_q;

`ifdef DIV_ZERO_FAST_EN
    logic dz_q, dz_d;

    // dz is sticky until the next accepted start re-evaluates it.
    always_comb begin
        dz_d = dz_q;
        if (accept) begin
            dz_d = (b == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dz_q <= 1'b0;
        end else begin
            dz_q <= dz_d;
        end
    end

    assign dz = dz_q;
`else
    assign dz = 1'b0;
`endif

endmodule

// File: tb/tb_seq_nonrestoring_divider.sv
// tb/tb_seq_nonrestoring_divider.sv - directed and randomized checks for seq_nonrestoring_divider
module tb_seq_nonrestoring_divider;

    localparam int WIDTH = 24;
    localparam int LAT   = WIDTH + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             ready;
    logic             dz;

    int checks = 0;
    int passed = 0;

    seq_nonrestoring_divider #(.WIDTH(WIDTH), .CNTW(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .ready (ready),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat counts edges from the accepting edge (inclusive) to the edge after which ready is seen.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          output logic [WIDTH-1:0] rq, output logic [WIDTH-1:0] rr,
                          output int lat);
        a     = ta;
        b     = tb;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (!ready && lat < 80) begin
            tick();
            lat++;
        end
        rq = q;
        rr = r;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        tick();
        tick();
        checks++;
        if ({q, r, busy, ready, dz} !== '0) $display("FAIL reset_outputs: q=%0d r=%0d busy=%0b ready=%0b dz=%0b, expected all 0", q, r, busy, ready, dz);
        else passed++;
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0) $display("FAIL reset_idle: busy=%0b ready=%0b, expected 0 0", busy, ready);
        else passed++;
    endtask

    task automatic test_basic();
        int lat;
        a = 24'd100; b = 24'd7; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || ready !== 1'b0) $display("FAIL basic_busy: busy=%0b ready=%0b, expected 1 0", busy, ready);
        else passed++;
        lat = 1;
        while (!ready && lat < 80) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== LAT) $display("FAIL basic_latency: got %0d edges, expected %0d", lat, LAT);
        else passed++;
        checks++;
        if (q !== 24'd14 || r !== 24'd2 || busy !== 1'b0) $display("FAIL basic_result: q=%0d r=%0d busy=%0b, expected q=14 r=2 busy=0", q, r, busy);
        else passed++;
        tick();
        checks++;
        if (ready !== 1'b0) $display("FAIL basic_pulse_width: ready=%0b, expected 0", ready);
        else passed++;
        tick();
        tick();
        checks++;
        if (q !== 24'd14 || r !== 24'd2) $display("FAIL basic_hold: q=%0d r=%0d, expected 14 2", q, r);
        else passed++;
    endtask

    task automatic test_boundaries();
        logic [WIDTH-1:0] va [4] = '{24'hFFFFFF, 24'd5, 24'hFFFFFF, 24'd0};
        logic [WIDTH-1:0] vb [4] = '{24'd1,      24'd9, 24'hFFFFFF, 24'd5};
        logic [WIDTH-1:0] eq [4] = '{24'hFFFFFF, 24'd0, 24'd1,      24'd0};
        logic [WIDTH-1:0] er [4] = '{24'd0,      24'd5, 24'd0,      24'd0};
        logic [WIDTH-1:0] rq, rr;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], rq, rr, lat);
            checks++;
            if (rq !== eq[i] || rr !== er[i] || lat !== LAT)
                $display("FAIL boundary_%0d: q=%h r=%h lat=%0d, expected q=%h r=%h lat=%0d", i, rq, rr, lat, eq[i], er[i], LAT);
            else passed++;
        end
    endtask

    task automatic test_div_zero();
        logic [WIDTH-1:0] rq, rr;
        int lat;
        run_op(24'd1000, 24'd0, rq, rr, lat);
`ifdef DIV_ZERO_FAST_EN
        checks++;
        if (rq !== 24'hFFFFFF || rr !== 24'd1000 || dz !== 1'b1 || lat !== 1)
            $display("FAIL div_zero_fast: q=%h r=%0d dz=%0b lat=%0d, expected q=ffffff r=1000 dz=1 lat=1", rq, rr, dz, lat);
        else passed++;
        tick();
        tick();
        checks++;
        if (dz !== 1'b1) $display("FAIL div_zero_hold: dz=%0b, expected 1", dz);
        else passed++;
        run_op(24'd9, 24'd3, rq, rr, lat);
        checks++;
        if (dz !== 1'b0 || rq !== 24'd3 || rr !== 24'd0) $display("FAIL div_zero_clear: dz=%0b q=%0d r=%0d, expected dz=0 q=3 r=0", dz, rq, rr);
        else passed++;
`else
        checks++;
        if (rq !== 24'hFFFFFF || rr !== 24'd1000 || dz !== 1'b0 || lat !== LAT)
            $display("FAIL div_zero_slow: q=%h r=%0d dz=%0b lat=%0d, expected q=ffffff r=1000 dz=0 lat=%0d", rq, rr, dz, lat, LAT);
        else passed++;
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] op_a [105];
        logic [WIDTH-1:0] op_b [105];
        logic             exp_rdy;
        for (int i = 0; i < 105; i++) begin
            op_a[i] = 24'(1000 + 37 * i);
            op_b[i] = 24'(3 + (i % 11));
        end
        // Accepts happen at edges 0, 26, 52, 78; ready follows 25 edges later.
        for (int i = 0; i < 105; i++) begin
            a     = op_a[i];
            b     = op_b[i];
            start = (i <= 78);
            tick();
            exp_rdy = (i == 25) || (i == 51) || (i == 77) || (i == 103);
            checks++;
            if (ready !== exp_rdy) $display("FAIL b2b_ready_edge%0d: ready=%0b, expected %0b", i, ready, exp_rdy);
            else passed++;
            if (exp_rdy) begin
                checks++;
                if (q !== op_a[i-25] / op_b[i-25] || r !== op_a[i-25] % op_b[i-25])
                    $display("FAIL b2b_result_edge%0d: q=%0d r=%0d, expected q=%0d r=%0d", i, q, r,
                             op_a[i-25] / op_b[i-25], op_a[i-25] % op_b[i-25]);
                else passed++;
            end
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort();
        logic [WIDTH-1:0] rq, rr;
        int lat;
        logic seen;
        a = 24'd200; b = 24'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({q, r, busy, ready, dz} !== '0) $display("FAIL abort_outputs: q=%0d r=%0d busy=%0b ready=%0b dz=%0b, expected all 0", q, r, busy, ready, dz);
        else passed++;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ready || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL abort_no_ready: activity seen=%0b, expected 0", seen);
        else passed++;
        run_op(24'd200, 24'd3, rq, rr, lat);
        checks++;
        if (rq !== 24'd66 || rr !== 24'd2 || lat !== LAT) $display("FAIL abort_rerun: q=%0d r=%0d lat=%0d, expected q=66 r=2 lat=%0d", rq, rr, lat, LAT);
        else passed++;
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ra, rb, rq, rr;
        logic [47:0]      recon;
        int lat;
        for (int k = 0; k < 300; k++) begin
            ra = 24'($urandom);
            rb = (k % 2 == 1) ? 24'($urandom_range(1, 255)) : 24'($urandom_range(1, 24'hFFFFFF));
            run_op(ra, rb, rq, rr, lat);
            recon = 48'(rq) * 48'(rb) + 48'(rr);
            checks++;
            if (recon !== 48'(ra) || lat !== LAT)
                $display("FAIL rand_identity_%0d: a=%0d b=%0d q=%0d r=%0d lat=%0d, expected q*b+r=a lat=%0d", k, ra, rb, rq, rr, lat, LAT);
            else passed++;
            checks++;
            if (!(rr < rb)) $display("FAIL rand_rem_bound_%0d: r=%0d, expected below b=%0d", k, rr, rb);
            else passed++;
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
